// File: rtl/fnd_scan_sequencer.sv
// fnd_scan_sequencer
// Drives a 4-digit common-anode seven-segment display. It contains two cooperating parts:
//  * a scan sequencer that walks digits 0..3. Each digit slot starts with a blanking
//    window (all commons off) to suppress ghosting, followed by a drive window.
//  * a serial binary-to-BCD converter (shift-add-3). It accepts a 14-bit value over
//    valid/ready, and hands the result to the display only at a frame boundary. A frame
//    therefore never mixes old and new digits.
// Every output is taken straight from a flop.
module fnd_scan_sequencer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1_000,
  parameter int BLANK_CYC = 1_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] i_count,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_lz_blank,
  input  logic [3:0]  i_dp_mask,
  output logic [3:0]  o_fnd_com,
  output logic [3:0]  o_bcd,
  output logic        o_dp,
  output logic        o_frame_start
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int DIGIT_CYC = CLK_HZ / SCAN_HZ;
  localparam int TW        = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;

  localparam logic [TW-1:0] SLOT_LAST  = TW'(DIGIT_CYC - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);
  localparam logic [13:0]   MAX_VAL    = 14'd9999;
  localparam logic [3:0]    LAST_ITER  = 4'd13;   // 14 shift-add-3 iterations: 0..13
  localparam logic [3:0]    BLANK_CODE = 4'hF;

  // ---------------------------------------------------------------------------
  // Scan FSM state
  // The counters describe the slot position that the output registers present on
  // the next cycle. Their reset values (digit 0, slot 0, BLANK) therefore make the
  // first cycle after reset release the start of a frame.
  // ---------------------------------------------------------------------------
  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_DRIVE = 1'b1
  } scan_state_e;

  scan_state_e     scan_state_q, scan_state_d;
  logic [TW-1:0]   slot_cnt_q,   slot_cnt_d;
  logic [1:0]      digit_idx_q,  digit_idx_d;

  // ---------------------------------------------------------------------------
  // Converter FSM state and datapath
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    CONV_IDLE = 2'd0,
    CONV_RUN  = 2'd1,
    CONV_DONE = 2'd2
  } conv_state_e;

  conv_state_e     conv_state_q, conv_state_d;
  logic [13:0]     bin_q,        bin_d;         // binary value being shifted out
  logic [15:0]     bcd_q,        bcd_d;         // BCD accumulator; the shadow while in DONE
  logic [3:0]      iter_q,       iter_d;
  logic            done_fresh_q, done_fresh_d;  // high on the first DONE cycle
  logic [15:0]     display_q,    display_d;     // committed digits, ones digit in [3:0]

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic [3:0]      fnd_com_q,     fnd_com_d;
  logic [3:0]      bcd_out_q,     bcd_out_d;
  logic            dp_q,          dp_d;
  logic            frame_start_q, frame_start_d;
  logic            ready_q,       ready_d;

  // ---------------------------------------------------------------------------
  // Helper nets
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            commit;
  logic [13:0]     count_clamped;
  logic [15:0]     bcd_adj;   // accumulator after the add-3 correction
  logic [3:0]      nz;        // committed digit is nonzero
  logic [3:0]      lz_hide;   // digit is a suppressed leading zero

  // Values above 9999 cannot be shown on four digits. They saturate rather than wrap.
  assign count_clamped = (i_count > MAX_VAL) ? MAX_VAL : i_count;

  // Handshake: accept only while IDLE. A value offered at any other time is dropped,
  // and the source has to keep offering it.
  assign accept = i_valid & (conv_state_q == CONV_IDLE);

  // Commit on a frame-start cycle only. The first DONE cycle is excluded, so a
  // result that lands exactly on a frame start waits for the following frame.
  assign commit = (conv_state_q == CONV_DONE) & frame_start_q & ~done_fresh_q;

  // Per-digit logic: the add-3 correction for the converter, and leading-zero detection
  // on the digits that the display will show.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? (bcd_q[4*gi +: 4] + 4'd3)
                                                           : bcd_q[4*gi +: 4];
    assign nz[gi] = |display_d[4*gi +: 4];
    if (gi == 0) begin : g_ones
      // The ones digit always shows, so zero appears as "   0".
      assign lz_hide[gi] = 1'b0;
    end else begin : g_upper
      // Hidden when this digit and every digit above it are zero.
      assign lz_hide[gi] = i_lz_blank & ~(|nz[3:gi]);
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------

  // Scan state register: digit index, slot timer and phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_state_q <= SCAN_BLANK;
      slot_cnt_q   <= '0;
      digit_idx_q  <= 2'd0;
    end else begin
      scan_state_q <= scan_state_d;
      slot_cnt_q   <= slot_cnt_d;
      digit_idx_q  <= digit_idx_d;
    end
  end

  // Scan next state: advance the slot timer, switch BLANK->DRIVE, and move to the next digit.
  always_comb begin
    scan_state_d = scan_state_q;
    slot_cnt_d   = slot_cnt_q + TW'(1);
    digit_idx_d  = digit_idx_q;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d   = '0;
      digit_idx_d  = digit_idx_q + 2'd1;
      scan_state_d = SCAN_BLANK;
    end else if (slot_cnt_q == BLANK_LAST) begin
      scan_state_d = SCAN_DRIVE;
    end
  end

  // ---------------------------------------------------------------------------
  // Converter FSM
  // ---------------------------------------------------------------------------

  // Converter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      conv_state_q <= CONV_IDLE;
    end else begin
      conv_state_q <= conv_state_d;
    end
  end

  // Converter next state: IDLE -> RUN on accept, RUN -> DONE after 14 iterations,
  // DONE -> IDLE once the shadow is committed.
  always_comb begin
    conv_state_d = conv_state_q;
    case (conv_state_q)
      CONV_IDLE: if (accept)             conv_state_d = CONV_RUN;
      CONV_RUN:  if (iter_q == LAST_ITER) conv_state_d = CONV_DONE;
      CONV_DONE: if (commit)             conv_state_d = CONV_IDLE;
      default:                           conv_state_d = CONV_IDLE;
    endcase
  end

  // Converter datapath next values: load on accept, do one shift-add-3 step per RUN cycle,
  // and copy the shadow into the display on commit.
  always_comb begin
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    iter_d       = iter_q;
    display_d    = commit ? bcd_q : display_q;
    done_fresh_d = (conv_state_q == CONV_RUN) && (conv_state_d == CONV_DONE);
    if (accept) begin
      bin_d  = count_clamped;
      bcd_d  = '0;
      iter_d = '0;
    end else if (conv_state_q == CONV_RUN) begin
      {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
      iter_d         = iter_q + 4'd1;
    end
  end

  // Converter datapath registers and committed display digits. Reset clears the
  // shadow, so a value that was still in flight never reaches the display.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q        <= '0;
      bcd_q        <= '0;
      iter_q       <= '0;
      done_fresh_q <= 1'b0;
      display_q    <= '0;
    end else begin
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      iter_q       <= iter_d;
      done_fresh_q <= done_fresh_d;
      display_q    <= display_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  // Output decode. The display digits are read from display_d, so a commit is visible
  // on the very next driven cycle, whatever the length of the blanking window.
  always_comb begin
    fnd_com_d     = 4'b1111;
    bcd_out_d     = BLANK_CODE;
    dp_d          = 1'b1;
    frame_start_d = (scan_state_q == SCAN_BLANK) && (slot_cnt_q == '0) && (digit_idx_q == 2'd0);
    ready_d       = (conv_state_d == CONV_IDLE);
    if (scan_state_q == SCAN_DRIVE) begin
      fnd_com_d = ~(4'b0001 << digit_idx_q);
      bcd_out_d = lz_hide[digit_idx_q] ? BLANK_CODE : display_d[{digit_idx_q, 2'b00} +: 4];
      dp_d      = ~i_dp_mask[digit_idx_q];
    end
  end

  // Output registers. Their reset values give a dark display that is ready to accept a value.
  always_ff @(posedge clk) begin
    if (reset) begin
      fnd_com_q     <= 4'b1111;
      bcd_out_q     <= BLANK_CODE;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      fnd_com_q     <= fnd_com_d;
      bcd_out_q     <= bcd_out_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
      ready_q       <= ready_d;
    end
  end

  assign o_fnd_com     = fnd_com_q;
  assign o_bcd         = bcd_out_q;
  assign o_dp          = dp_q;
  assign o_frame_start = frame_start_q;
  assign o_ready       = ready_q;

endmodule
